pll_lock_sequencer: RTL and testbench

- Controller for the SoC system PLL's reset and lock handshake, running on the free-running 50 MHz reference clock.
- Pulses the PLL reset, waits for lock with a timeout and bounded retries, and requires lock to stay stable before releasing the downstream reset.
- Monitors for loss of lock during operation and re-sequences the PLL when it occurs.
- Sits between the board reset and the PLL wrapper; gates the reset of all logic clocked by the 400 MHz outclk_0.

---
 rtl/pll_lock_sequencer.sv | 143 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock handshake controller on the reference clock: pulses the PLL reset, waits for a
// stable lock with bounded retries, releases the downstream reset and re-sequences on lock loss.
module pll_lock_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_W               = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       user_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] lol_count,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        StResetPll  = 3'd0,
        StWaitLock  = 3'd1,
        StStabilize = 3'd2,
        StRun       = 3'd3,
        StFault     = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       MaxRetries  = 4'(MAX_RETRIES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       lol_q, lol_d;
    logic             sync1_q, sync2_q;
    logic             locked_s;
    logic             pll_rst_q, pll_rst_d;
    logic             user_rst_q, user_rst_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;

    assign locked_s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        lol_d   = lol_q;

        if (restart_req) begin
            state_d = StResetPll;
            retry_d = '0;
        end else begin
            unique case (state_q)
                StResetPll: begin
                    if (cnt_q == RstLast) state_d = StWaitLock;
                end
                StWaitLock: begin
                    if (locked_s) begin
                        state_d = StStabilize;
                    end else if (cnt_q == TimeoutLast) begin
                        if (retry_q == MaxRetries) begin
                            state_d = StFault;
                        end else begin
                            retry_d = retry_q + 4'd1;
                            state_d = StResetPll;
                        end
                    end
                end
                StStabilize: begin
                    if (!locked_s) begin
                        state_d = StWaitLock;
                    end else if (cnt_q == StableLast) begin
                        state_d = StRun;
                        retry_d = '0;
                    end
                end
                StRun: begin
                    if (!locked_s) begin
                        state_d = StResetPll;
                        if (lol_q != 8'hff) lol_d = lol_q + 8'd1;
                    end
                end
                StFault: ;
                default: state_d = StResetPll;
            endcase
        end

        // Counter restarts on every state entry, including a restart into RESET_PLL itself.
        if (restart_req || (state_d != state_q)) cnt_d = '0;
        if (state_q == StRun || state_q == StFault) begin
            if (!(restart_req || (state_d != state_q))) cnt_d = cnt_q;
        end
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_comb begin
        pll_rst_d  = (state_d == StResetPll) || (state_d == StFault);
        user_rst_d = (state_d != StRun);
        ready_d    = (state_d == StRun);
        fault_d    = (state_d == StFault);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= StResetPll;
            cnt_q      <= '0;
            retry_q    <= '0;
            lol_q      <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            pll_rst_q  <= 1'b1;
            user_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            lol_q      <= lol_d;
            sync1_q    <= pll_locked;
            sync2_q    <= sync1_q;
            pll_rst_q  <= pll_rst_d;
            user_rst_q <= user_rst_d;
            ready_q    <= ready_d;
            fault_q    <= fault_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign user_rst    = user_rst_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign lol_count   = lol_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed and randomized checks of pll_lock_sequencer; expected timing comes from the edge-count
// rules of the handshake rather than from a copy of the state machine.
module tb_pll_lock_sequencer;

    localparam int RST    = 4;
    localparam int STABLE = 8;
    localparam int TOUT   = 32;
    localparam int MAXR   = 2;

    logic       refclk = 1'b0;
    logic       rst, pll_locked, restart_req;
    logic       pll_rst, user_rst, ready, fault;
    logic [3:0] retry_count;
    logic [7:0] lol_count;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int lol_exp;
    int n;
    int d;
    int r;
    int len;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES   (RST),
        .LOCK_STABLE_CYCLES (STABLE),
        .LOCK_TIMEOUT_CYCLES(TOUT),
        .MAX_RETRIES        (MAXR),
        .CNT_W              (17)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .restart_req(restart_req),
        .pll_rst    (pll_rst),
        .user_rst   (user_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count),
        .lol_count  (lol_count),
        .state_dbg  (state_dbg)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later and check the output invariants.
    task automatic tick();
        @(posedge refclk);
        #1;
        chk("inv_ready_implies_released", 32'(ready & (user_rst | pll_rst)), 32'd0);
        chk("inv_fault_and_ready", 32'(fault & ready), 32'd0);
        chk("inv_pll_rst_implies_user_rst", 32'(pll_rst & ~user_rst), 32'd0);
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    // Ticks until pll_rst equals lvl; returns the tick count, or -1 if the budget expires.
    task automatic until_pll_rst(input logic lvl, output int cnt);
        cnt = 0;
        while (pll_rst !== lvl && cnt < 200) begin
            tick();
            cnt++;
        end
        if (pll_rst !== lvl) cnt = -1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        chk({tag, "_user_rst"}, 32'(user_rst), 32'd1);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_state"}, 32'(state_dbg), 32'd0);
        chk({tag, "_retry"}, 32'(retry_count), 32'd0);
        chk({tag, "_lol"}, 32'(lol_count), 32'd0);
    endtask

    // Raise lock while waiting; ready must rise on the (STABLE+2)th edge after it is sampled.
    task automatic acquire(input string tag);
        pll_locked = 1'b1;
        ticks(STABLE + 2);
        chk({tag, "_ready_early"}, 32'(ready), 32'd0);
        chk({tag, "_user_rst_early"}, 32'(user_rst), 32'd1);
        tick();
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_user_rst"}, 32'(user_rst), 32'd0);
        chk({tag, "_state_run"}, 32'(state_dbg), 32'd3);
        chk({tag, "_retry"}, 32'(retry_count), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        pll_locked = 1'b0;
        restart_req = 1'b0;
        lol_exp = 0;
        ticks(3);
        chk_reset_vals("reset");

        // Nominal acquisition
        rst = 1'b0;
        until_pll_rst(1'b0, n);
        chk("nom_pll_rst_len", n, RST);
        chk("nom_state_wait", 32'(state_dbg), 32'd1);
        ticks(10);
        chk("nom_still_wait", 32'(state_dbg), 32'd1);
        acquire("nom");

        // Loss of lock in RUN, then full re-sequence with lock restored
        pll_locked = 1'b0;
        ticks(2);
        chk("lol_ready_hold", 32'(ready), 32'd1);
        tick();
        lol_exp = 1;
        chk("lol_ready_fall", 32'(ready), 32'd0);
        chk("lol_user_rst", 32'(user_rst), 32'd1);
        chk("lol_state", 32'(state_dbg), 32'd0);
        chk("lol_count", 32'(lol_count), 32'(lol_exp));
        pll_locked = 1'b1;
        ticks(RST + STABLE);
        chk("lol_reseq_early", 32'(ready), 32'd0);
        tick();
        chk("lol_reseq_ready", 32'(ready), 32'd1);

        // One-cycle glitch late in STABILIZE
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        chk("rq_state", 32'(state_dbg), 32'd0);
        chk("rq_ready", 32'(ready), 32'd0);
        chk("rq_lol", 32'(lol_count), 32'(lol_exp));
        ticks(10);
        chk("gl_in_stab", 32'(state_dbg), 32'd2);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        ticks(2);
        chk("gl_back_wait", 32'(state_dbg), 32'd1);
        tick();
        chk("gl_restab", 32'(state_dbg), 32'd2);
        ticks(STABLE - 1);
        chk("gl_ready_early", 32'(ready), 32'd0);
        tick();
        chk("gl_ready", 32'(ready), 32'd1);
        chk("gl_retry", 32'(retry_count), 32'd0);

        // restart_req coincident with lock loss in RUN: lol_count unchanged
        pll_locked = 1'b0;
        ticks(2);
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        chk("coin_state", 32'(state_dbg), 32'd0);
        chk("coin_lol", 32'(lol_count), 32'(lol_exp));
        chk("coin_retry", 32'(retry_count), 32'd0);

        // No lock: MAXR+1 pulses separated by timeouts, then FAULT
        for (int p = 0; p <= MAXR; p++) begin
            until_pll_rst(1'b0, len);
            chk("nolock_pulse_len", len, RST);
            until_pll_rst(1'b1, len);
            chk("nolock_wait_len", len, TOUT);
            if (p < MAXR) begin
                chk("nolock_state_retry", 32'(state_dbg), 32'd0);
                chk("nolock_retry", 32'(retry_count), 32'(p + 1));
            end else begin
                chk("nolock_state_fault", 32'(state_dbg), 32'd4);
                chk("nolock_fault", 32'(fault), 32'd1);
                chk("nolock_retry_max", 32'(retry_count), 32'(MAXR));
            end
        end
        ticks(5);
        chk("fault_hold", 32'(fault), 32'd1);
        chk("fault_pll_rst", 32'(pll_rst), 32'd1);
        chk("fault_state", 32'(state_dbg), 32'd4);

        // Recovery; lock arrives at the last moment before the timeout
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        chk("rec_state", 32'(state_dbg), 32'd0);
        chk("rec_fault", 32'(fault), 32'd0);
        chk("rec_retry", 32'(retry_count), 32'd0);
        until_pll_rst(1'b0, n);
        chk("rec_pll_rst_len", n, RST);
        ticks(TOUT - 3);
        acquire("rec");

        // rst beats restart_req in STABILIZE
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        ticks(RST + 3);
        chk("prio_in_stab", 32'(state_dbg), 32'd2);
        rst = 1'b1;
        restart_req = 1'b1;
        pll_locked = 1'b0;
        tick();
        chk_reset_vals("prio_rst");
        rst = 1'b0;
        restart_req = 1'b0;
        lol_exp = 0;

        // Randomized acquisition delay, then repeated random loss events (saturating count)
        until_pll_rst(1'b0, n);
        chk("rnd_pll_rst_len", n, RST);
        d = int'($urandom_range(0, TOUT - 3));
        ticks(d);
        acquire("rnd");
        for (int i = 0; i < 260; i++) begin
            r = int'($urandom_range(0, 15));
            ticks(r);
            chk("rnd_run_ready", 32'(ready), 32'd1);
            len = int'($urandom_range(1, 4));
            for (int k = 1; k <= RST + STABLE + 4; k++) begin
                pll_locked = (k <= len) ? 1'b0 : 1'b1;
                tick();
                chk("rnd_ready_profile", 32'(ready),
                    32'((k <= 2) || (k == RST + STABLE + 4)));
                if (k == 3) begin
                    lol_exp = (lol_exp < 255) ? lol_exp + 1 : 255;
                    chk("rnd_lol", 32'(lol_count), 32'(lol_exp));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
